fir_sample_pacer: RTL and testbench



---
 rtl/fir_sample_pacer_pkg.sv | 20 ++
 rtl/fir_sample_pacer_if.sv | 28 ++
 rtl/fir_sample_pacer_sample_fifo.sv | 65 ++++++
 rtl/fir_sample_pacer.sv | 96 +++++++++
 tb/tb_fir_sample_pacer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_sample_pacer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_pkg
// Brief    : Shared sample type, default width and pacer state encoding.
// Revision : 1.0
// ============================================================================
package fir_pkg;

    localparam int c_sample_w = 20;

    typedef logic signed [c_sample_w-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } pacer_state_t;

endpackage
`default_nettype wire

// File: rtl/fir_sample_pacer_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_sample_pacer_if
// Brief    : Source valid/ready stream plus FIR strobe/completion handshake.
// Revision : 1.0
// ============================================================================
interface fir_sample_pacer_if #(
    parameter int N = fir_pkg::c_sample_w
);
    logic signed [N-1:0] s_data;
    logic                s_valid;
    logic                s_ready;
    logic signed [N-1:0] fir_in;
    logic                fir_input_ready;
    logic                fir_output_ready;

    // master is the pacer; slave is the source/filter environment
    modport master (
        input  s_data, s_valid, fir_output_ready,
        output s_ready, fir_in, fir_input_ready
    );

    modport slave (
        output s_data, s_valid, fir_output_ready,
        input  s_ready, fir_in, fir_input_ready
    );
endinterface
`default_nettype wire

// File: rtl/fir_sample_pacer_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sample_fifo
// Brief    : Power-of-two sample FIFO with occupancy counter, no fall-through.
// Revision : 1.0
// ============================================================================
module sample_fifo #(
    parameter int N     = 20,
    parameter int DEPTH = 8
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   i_push,
    input  wire logic [N-1:0]           i_data,
    input  wire logic                   i_pop,
    output logic      [N-1:0]           o_data,
    output logic      [$clog2(DEPTH):0] o_level,
    output logic                        o_full,
    output logic                        o_empty
);
    localparam int c_aw = $clog2(DEPTH);

    logic [N-1:0]    r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_level;
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_level == (c_aw+1)'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Storage is not reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/fir_sample_pacer.sv
`default_nettype none
// ============================================================================
// Module   : fir_sample_pacer
// Brief    : Buffers source samples and hands them to the FIR one at a time.
// Revision : 1.0
// ============================================================================
module fir_sample_pacer
    import fir_pkg::*;
#(
    parameter int N       = c_sample_w,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  wire logic                   ck,
    input  wire logic                   rst,
    fir_sample_pacer_if.master          bus,
    output logic      [$clog2(DEPTH):0] level,
    output logic                        timeout_err
);
    localparam int                c_cw       = $clog2(TIMEOUT + 1);
    localparam logic [c_cw-1:0]   c_cnt_last = c_cw'(TIMEOUT - 1);

    pacer_state_t        r_state;
    logic signed [N-1:0] r_fir_in;
    logic                r_fir_input_ready;
    logic                r_timeout_err;
    logic [c_cw-1:0]     r_cnt;

    logic [N-1:0]        w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_s_ready;
    logic                w_pop;

    // s_ready is held low during reset so nothing lands in a FIFO being cleared.
    assign w_s_ready = !w_full && !rst;
    assign w_pop     = (r_state == IDLE) && !w_empty;

    sample_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (ck),
        .rst     (rst),
        .i_push  (bus.s_valid && w_s_ready),
        .i_data  (bus.s_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_level (level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.s_ready         = w_s_ready;
    assign bus.fir_in          = r_fir_in;
    assign bus.fir_input_ready = r_fir_input_ready;
    assign timeout_err         = r_timeout_err;

    always_ff @(posedge ck) begin
        if (rst) begin
            r_state           <= IDLE;
            r_fir_in          <= '0;
            r_fir_input_ready <= 1'b0;
            r_timeout_err     <= 1'b0;
            r_cnt             <= '0;
        end else begin
            r_fir_input_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_fir_in          <= w_head;
                        r_fir_input_ready <= 1'b1;
                        r_state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= BUSY;
                end
                BUSY: begin
                    // Completion wins over a timeout landing on the same cycle.
                    if (bus.fir_output_ready) begin
                        r_state <= IDLE;
                    end else if (r_cnt == c_cnt_last) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fir_sample_pacer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_sample_pacer
// Brief    : Directed self-checking bench for fir_sample_pacer.
// Revision : 1.0
// ============================================================================
module tb_fir_sample_pacer;
    import fir_pkg::*;

    localparam int N       = 20;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 64;

    logic                   ck;
    logic                   rst;
    logic [$clog2(DEPTH):0] level;
    logic                   timeout_err;

    int n_checks = 0;
    int n_pass   = 0;
    int src_acc  = 0;
    bit src_on   = 0;

    fir_sample_pacer_if #(.N(N)) bus ();

    fir_sample_pacer #(
        .N       (N),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .ck          (ck),
        .rst         (rst),
        .bus         (bus.master),
        .level       (level),
        .timeout_err (timeout_err)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    // One clock; when src_on, it also acts as a source streaming 100..109.
    task automatic tick();
        bit acc_now;
        acc_now = src_on && bus.s_valid && bus.s_ready;
        @(posedge ck);
        #1;
        if (acc_now) begin
            src_acc++;
            if (src_acc < 10) begin
                bus.s_data = N'(100 + src_acc);
            end else begin
                bus.s_valid = 1'b0;
                src_on      = 1'b0;
            end
        end
    endtask

    task automatic push(input int d);
        bus.s_data  = N'(d);
        bus.s_valid = 1'b1;
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_strobe(output int v, output int lat);
        lat = 0;
        while (!bus.fir_input_ready && lat < 200) begin
            tick();
            lat++;
        end
        if (!bus.fir_input_ready) check("strobe_wait_expired", 0, 1);
        v = int'(bus.fir_in);
    endtask

    // Called in the strobe cycle: step into BUSY, then pulse completion.
    task automatic fir_done();
        tick();
        bus.fir_output_ready = 1'b1;
        tick();
        bus.fir_output_ready = 1'b0;
    endtask

    initial begin
        int v;
        int lat;
        int strobes;

        rst                  = 1'b1;
        bus.s_data           = '0;
        bus.s_valid          = 1'b0;
        bus.fir_output_ready = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_s_ready", int'(bus.s_ready), 0);
        check("rst_level", int'(level), 0);
        check("rst_strobe", int'(bus.fir_input_ready), 0);
        check("rst_fir_in", int'(bus.fir_in), 0);
        check("rst_timeout_err", int'(timeout_err), 0);
        rst = 1'b0;
        #1;
        check("post_rst_s_ready", int'(bus.s_ready), 1);
        tick(); tick();

        // 1: single sample latency and completion
        push(1234);
        check("t1_level_after_push", int'(level), 1);
        check("t1_no_strobe_yet", int'(bus.fir_input_ready), 0);
        tick();
        check("t1_strobe", int'(bus.fir_input_ready), 1);
        check("t1_fir_in", int'(bus.fir_in), 1234);
        check("t1_level_popped", int'(level), 0);
        tick();
        check("t1_strobe_one_cycle", int'(bus.fir_input_ready), 0);
        check("t1_busy", int'(dut.r_state), int'(BUSY));
        repeat (21) tick();
        bus.fir_output_ready = 1'b1;
        tick();
        bus.fir_output_ready = 1'b0;
        check("t1_idle", int'(dut.r_state), int'(IDLE));
        check("t1_level_end", int'(level), 0);
        check("t1_no_err", int'(timeout_err), 0);

        // 2: burst of 10 while the FIR holds sample 99
        push(99);
        wait_strobe(v, lat);
        check("t2_first", v, 99);
        tick();
        src_acc     = 0;
        src_on      = 1'b1;
        bus.s_data  = N'(100);
        bus.s_valid = 1'b1;
        for (int i = 0; i < 20 && bus.s_ready; i++) tick();
        check("t2_accepted_before_full", src_acc, 8);
        check("t2_level_full", int'(level), 8);
        check("t2_s_ready_full", int'(bus.s_ready), 0);
        for (int k = 0; k < 10; k++) begin
            fir_done();
            if (k == 0) begin
                check("t2_full_in_pop_cycle_s_ready", int'(bus.s_ready), 0);
                check("t2_full_in_pop_cycle_level", int'(level), 8);
            end
            wait_strobe(v, lat);
            check($sformatf("t2_order_%0d", k), v, 100 + k);
        end
        check("t2_all_accepted", src_acc, 10);
        check("t2_level_drained", int'(level), 0);

        // 3: simultaneous push and pop at level 3
        tick();
        push(200); push(201); push(202);
        bus.fir_output_ready = 1'b1;
        tick();
        bus.fir_output_ready = 1'b0;
        check("t3_level_pre", int'(level), 3);
        check("t3_idle", int'(dut.r_state), int'(IDLE));
        push(203);
        check("t3_level_unchanged", int'(level), 3);
        check("t3_strobe", int'(bus.fir_input_ready), 1);
        check("t3_oldest_popped", int'(bus.fir_in), 200);
        for (int k = 1; k < 4; k++) begin
            fir_done();
            wait_strobe(v, lat);
            check($sformatf("t3_order_%0d", k), v, 200 + k);
        end

        // 4: timeout with sample 300 waiting behind
        bus.s_data  = N'(300);
        bus.s_valid = 1'b1;
        tick();
        bus.s_valid = 1'b0;
        repeat (TIMEOUT - 1) tick();
        check("t4_no_err_last_busy", int'(timeout_err), 0);
        check("t4_still_busy", int'(dut.r_state), int'(BUSY));
        tick();
        check("t4_err_set", int'(timeout_err), 1);
        check("t4_idle_after_to", int'(dut.r_state), int'(IDLE));
        wait_strobe(v, lat);
        check("t4_next_sample", v, 300);
        check("t4_next_latency", lat, 1);
        fir_done();
        tick();
        check("t4_err_sticky", int'(timeout_err), 1);

        // 5: completion on the final BUSY cycle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("t5_err_cleared", int'(timeout_err), 0);
        push(400);
        wait_strobe(v, lat);
        check("t5_sample", v, 400);
        repeat (TIMEOUT) tick();
        check("t5_busy_last", int'(dut.r_state), int'(BUSY));
        bus.fir_output_ready = 1'b1;
        tick();
        bus.fir_output_ready = 1'b0;
        check("t5_no_err", int'(timeout_err), 0);
        check("t5_idle", int'(dut.r_state), int'(IDLE));
        bus.fir_output_ready = 1'b1;
        tick();
        bus.fir_output_ready = 1'b0;
        tick();
        check("t5_ignored_ready_no_strobe", int'(bus.fir_input_ready), 0);
        check("t5_ignored_ready_idle", int'(dut.r_state), int'(IDLE));

        // 6: reset mid-operation
        push(500);
        wait_strobe(v, lat);
        check("t6_sample", v, 500);
        tick();
        for (int k = 1; k <= 5; k++) push(500 + k);
        check("t6_level5", int'(level), 5);
        check("t6_busy", int'(dut.r_state), int'(BUSY));
        rst = 1'b1;
        #1;
        check("t6_s_ready_in_rst", int'(bus.s_ready), 0);
        tick();
        rst = 1'b0;
        #1;
        check("t6_level", int'(level), 0);
        check("t6_strobe", int'(bus.fir_input_ready), 0);
        check("t6_fir_in", int'(bus.fir_in), 0);
        check("t6_s_ready_after", int'(bus.s_ready), 1);
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.fir_input_ready) strobes++;
        end
        check("t6_no_stray_strobe", strobes, 0);
        push(600);
        wait_strobe(v, lat);
        check("t6_new_sample", v, 600);
        check("t6_new_latency", lat, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
